// File: rtl/svm_multi_scorer.sv
// Multi-class linear SVM scorer for the serial HOG feature stream.
// Scores N_CLS classes per window from one shared coefficient RAM and reports the argmax.
module svm_multi_scorer #(
    parameter int FEA_I  = 4,
    parameter int FEA_F  = 8,
    parameter int N_CLS  = 4,
    parameter int N_FEA  = 3780,
    parameter int N_SW   = 1200,
    parameter int SW_W   = 11,
    parameter int CLS_W  = 2,
    parameter int ADDR_W = 12,
    localparam int FEA_W  = FEA_I + FEA_F,
    localparam int ACC_W  = 2 * FEA_W + ADDR_W,
    localparam int RAM_DW = N_CLS * FEA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              i_valid,
    input  logic [FEA_W-1:0]  fea,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              write_en,
    input  logic [RAM_DW-1:0] i_data,
    output logic [RAM_DW-1:0] o_data_a,
    input  logic [FEA_W-1:0]  bias,
    input  logic [CLS_W-1:0]  b_sel,
    input  logic              b_load,
    input  logic [FEA_W-1:0]  thr,
    output logic              o_valid,
    output logic [CLS_W-1:0]  class_id,
    output logic [FEA_W-1:0]  result,
    output logic              is_person,
    output logic [SW_W-1:0]   sw_id
);
    localparam logic signed [ACC_W-1:0] SAT_HI =
        ACC_W'((64'sd1 <<< (FEA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
    localparam logic [FEA_W-1:0] RES_HI = {1'b0, {(FEA_W-1){1'b1}}};
    localparam logic [FEA_W-1:0] RES_LO = {1'b1, {(FEA_W-1){1'b0}}};

    logic [RAM_DW-1:0] ram [N_FEA];
    logic [RAM_DW-1:0] coef_q;
    logic [RAM_DW-1:0] o_data_a_q;

    logic [ADDR_W-1:0] fea_cnt_q, fea_cnt_d, rd_addr;
    logic [SW_W-1:0]   win_q, win_d, win_cur;
    logic              at_last;

    logic                    s1_v_q, s1_v_d, s1_first_q, s1_first_d;
    logic                    s1_last_q, s1_last_d;
    logic [SW_W-1:0]         s1_sw_q, s1_sw_d;
    logic signed [FEA_W-1:0] fea_q, fea_d;

    logic                        s2_v_q, s2_v_d, s2_first_q, s2_first_d;
    logic                        s2_last_q, s2_last_d;
    logic [SW_W-1:0]             s2_sw_q, s2_sw_d;
    logic signed [2*FEA_W-1:0]   prod_q [N_CLS];
    logic signed [2*FEA_W-1:0]   prod_d [N_CLS];

    logic                    s3_v_q, s3_v_d;
    logic [SW_W-1:0]         s3_sw_q, s3_sw_d;
    logic signed [ACC_W-1:0] acc_q [N_CLS];
    logic signed [ACC_W-1:0] acc_d [N_CLS];
    logic signed [FEA_W-1:0] bias_q [N_CLS];
    logic signed [FEA_W-1:0] bias_d [N_CLS];

    logic signed [ACC_W-1:0] best, best_sh, thr_full;
    logic [CLS_W-1:0]        best_idx;

    logic             o_valid_q, o_valid_d;
    logic [CLS_W-1:0] class_id_q, class_id_d;
    logic [FEA_W-1:0] result_q, result_d;
    logic             is_person_q, is_person_d;
    logic [SW_W-1:0]  sw_id_q, sw_id_d;

    // frame_start overrides the counters in the same cycle it is asserted
    always_comb begin
        rd_addr   = frame_start ? '0 : fea_cnt_q;
        win_cur   = frame_start ? '0 : win_q;
        at_last   = rd_addr == ADDR_W'(N_FEA - 1);
        fea_cnt_d = rd_addr;
        win_d     = win_cur;
        if (i_valid) begin
            fea_cnt_d = at_last ? '0 : rd_addr + ADDR_W'(1);
            if (at_last)
                win_d = (win_cur == SW_W'(N_SW - 1)) ? '0 : win_cur + SW_W'(1);
        end
        s1_v_d     = i_valid;
        s1_first_d = rd_addr == '0;
        s1_last_d  = at_last;
        s1_sw_d    = win_cur;
        fea_d      = i_valid ? $signed(fea) : fea_q;
    end

    always_comb begin
        s2_v_d     = s1_v_q;
        s2_first_d = s1_first_q;
        s2_last_d  = s1_last_q;
        s2_sw_d    = s1_sw_q;
        s3_v_d     = s2_v_q && s2_last_q;
        s3_sw_d    = s2_sw_q;
        for (int c = 0; c < N_CLS; c++) begin
            prod_d[c] = fea_q * $signed(coef_q[c*FEA_W +: FEA_W]);
            bias_d[c] = (b_load && b_sel == CLS_W'(c)) ? $signed(bias) : bias_q[c];
            acc_d[c]  = acc_q[c];
            if (s2_v_q)
                acc_d[c] = (s2_first_q ? (ACC_W'(bias_q[c]) <<< FEA_F) : acc_q[c])
                           + ACC_W'(prod_q[c]);
        end
    end

    // strict > keeps the lowest class index on ties
    always_comb begin
        best     = acc_q[0];
        best_idx = '0;
        for (int c = 1; c < N_CLS; c++) begin
            if (acc_q[c] > best) begin
                best     = acc_q[c];
                best_idx = CLS_W'(c);
            end
        end
        best_sh     = best >>> FEA_F;
        thr_full    = ACC_W'($signed(thr)) <<< FEA_F;
        o_valid_d   = s3_v_q;
        class_id_d  = class_id_q;
        result_d    = result_q;
        is_person_d = is_person_q;
        sw_id_d     = sw_id_q;
        if (s3_v_q) begin
            class_id_d = best_idx;
            if (best_sh > SAT_HI)
                result_d = RES_HI;
            else if (best_sh < SAT_LO)
                result_d = RES_LO;
            else
                result_d = best_sh[FEA_W-1:0];
            is_person_d = best >= thr_full;
            sw_id_d     = s3_sw_q;
        end
    end

    // read-first on both ports: a same-address write is seen next cycle
    always_ff @(posedge clk) begin
        if (write_en)
            ram[addr_a] <= i_data;
        coef_q <= ram[rd_addr];
        if (rst)
            o_data_a_q <= '0;
        else
            o_data_a_q <= ram[addr_a];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fea_cnt_q   <= '0;
            win_q       <= '0;
            s1_v_q      <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sw_q     <= '0;
            fea_q       <= '0;
            s2_v_q      <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_sw_q     <= '0;
            s3_v_q      <= 1'b0;
            s3_sw_q     <= '0;
            for (int c = 0; c < N_CLS; c++) begin
                prod_q[c] <= '0;
                acc_q[c]  <= '0;
                bias_q[c] <= '0;
            end
            o_valid_q   <= 1'b0;
            class_id_q  <= '0;
            result_q    <= '0;
            is_person_q <= 1'b0;
            sw_id_q     <= '0;
        end else begin
            fea_cnt_q   <= fea_cnt_d;
            win_q       <= win_d;
            s1_v_q      <= s1_v_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_sw_q     <= s1_sw_d;
            fea_q       <= fea_d;
            s2_v_q      <= s2_v_d;
            s2_first_q  <= s2_first_d;
            s2_last_q   <= s2_last_d;
            s2_sw_q     <= s2_sw_d;
            s3_v_q      <= s3_v_d;
            s3_sw_q     <= s3_sw_d;
            for (int c = 0; c < N_CLS; c++) begin
                prod_q[c] <= prod_d[c];
                acc_q[c]  <= acc_d[c];
                bias_q[c] <= bias_d[c];
            end
            o_valid_q   <= o_valid_d;
            class_id_q  <= class_id_d;
            result_q    <= result_d;
            is_person_q <= is_person_d;
            sw_id_q     <= sw_id_d;
        end
    end

    assign o_data_a  = o_data_a_q;
    assign o_valid   = o_valid_q;
    assign class_id  = class_id_q;
    assign result    = result_q;
    assign is_person = is_person_q;
    assign sw_id     = sw_id_q;
endmodule
